// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART sample transmit path.
// Frame geometry is fixed at 8N1: one start bit, eight data bits, one stop bit.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    localparam int DATA_BITS  = 8;
    localparam int FRAME_BITS = 10;

    function automatic int clks_per_bit(input longint clk_hz, input longint baud);
        return int'(clk_hz / baud);
    endfunction

endpackage

// File: rtl/sample_fifo.sv
// Single-clock first-word-fall-through FIFO buffering samples ahead of the serialiser.
// Pushes while full and pops while empty are ignored, so callers may drive them freely.
module sample_fifo
    import uart_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    generate
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
            $error("sample_fifo: DEPTH must be a power of 2 and at least 2");
        end
    endgenerate

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW + 1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Pointers are exactly AW bits wide so they wrap naturally at DEPTH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/uart_sample_tx.sv
// Buffers 8-bit waveform samples and streams them back to the host as 8N1 UART frames.
// Back-to-back frames chain straight from stop into the next start with no idle cycle.
module uart_sample_tx
    import uart_pkg::*;
#(
    parameter int CLK_HZ     = 50_000_000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic       tx,
    output logic       busy,
    output logic       overflow
);

    localparam int CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD);
    localparam int BW           = (CLKS_PER_BIT < 2) ? 1 : $clog2(CLKS_PER_BIT);

    localparam logic [1:0] S_IDLE  = IDLE;
    localparam logic [1:0] S_START = START;
    localparam logic [1:0] S_DATA  = DATA;
    localparam logic [1:0] S_STOP  = STOP;

    generate
        if (CLKS_PER_BIT < 2) begin : g_bad_baud
            $error("uart_sample_tx: CLK_HZ/BAUD must be at least 2");
        end
    endgenerate

    logic [1:0]           state;
    logic [BW-1:0]        baud_cnt;
    logic [2:0]           bit_idx;
    logic [DATA_BITS-1:0] shift;
    logic [DATA_BITS-1:0] head;
    logic                 full;
    logic                 empty;
    logic                 pop;
    logic                 baud_tc;

    sample_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (in_valid),
        .din   (in_data),
        .pop   (pop),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

    assign baud_tc  = (baud_cnt == BW'(CLKS_PER_BIT - 1));
    assign pop      = !empty && ((state == S_IDLE) || (state == S_STOP && baud_tc));
    assign in_ready = !full;
    assign busy     = (state != S_IDLE) || !empty;

    always_comb begin
        tx = 1'b1;
        case (state)
            S_START: tx = 1'b0;
            S_DATA:  tx = shift[0];
            default: tx = 1'b1;
        endcase
    end

    // Baud counter only advances outside IDLE; every bit is held CLKS_PER_BIT cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            overflow <= 1'b0;
        end else begin
            if (in_valid && full) overflow <= 1'b1;
            case (state)
                S_IDLE: begin
                    if (!empty) begin
                        shift    <= head;
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        state    <= S_START;
                    end
                end
                S_START: begin
                    if (baud_tc) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        state    <= S_DATA;
                    end else begin
                        baud_cnt <= baud_cnt + BW'(1);
                    end
                end
                S_DATA: begin
                    if (baud_tc) begin
                        baud_cnt <= '0;
                        shift    <= {1'b0, shift[DATA_BITS-1:1]};
                        if (bit_idx == 3'(DATA_BITS - 1)) begin
                            state <= S_STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + BW'(1);
                    end
                end
                S_STOP: begin
                    if (baud_tc) begin
                        baud_cnt <= '0;
                        if (!empty) begin
                            shift   <= head;
                            bit_idx <= '0;
                            state   <= S_START;
                        end else begin
                            state <= S_IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + BW'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/uart_sample_tx.md
Name: uart_sample_tx

Overview:
- Transmit-side counterpart to the in_valid/in_data UART sample receive path that feeds the wave generators.
- Accepts 8-bit waveform samples (for example, generator out_data strobed by the sample tick) into a small FIFO.
- Serialises each sample as a standard 8N1 UART frame on a single tx line.
- Closes the loop so samples can be streamed back to the host at a fixed baud rate.

Parameters:
- CLK_HZ, 50_000_000, system clock frequency in Hz.
- BAUD, 115200, line rate. CLKS_PER_BIT = CLK_HZ/BAUD (integer divide; 434 at defaults). Elaboration error if < 2.
- FIFO_DEPTH, 16, sample buffer entries. Must be a power of 2, at least 2.

Ports:
- clk  in  1  system clock, 50 MHz.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  sample present on in_data this cycle.
- in_data  in  8  sample byte, 0–255.
- in_ready  out  1  FIFO can accept; equals !full.
- tx  out  1  UART serial out, idle high.
- busy  out  1  high while a frame is in flight or the FIFO is non-empty.
- overflow  out  1  sticky; set when in_valid arrives while full. Cleared only by rst.

Behaviour:
- Reset (async, immediate): tx=1, busy=0, overflow=0, in_ready=1. FIFO is emptied, FSM=IDLE, baud and bit counters=0.
  - Reset mid-frame truncates the frame. tx returns high with no completion.
- Write: at an edge with in_valid && !full, the byte is pushed and count increments.
  - in_valid && full: byte is dropped, count unchanged, overflow<=1.
  - in_ready depends only on full. A pop in the same cycle does not admit a write when full.
- FSM states: IDLE, START, DATA, STOP. A baud counter runs 0..CLKS_PER_BIT-1 in every non-IDLE state.
  - Each bit is held exactly CLKS_PER_BIT cycles.
- IDLE: tx=1. If FIFO non-empty: pop the head into an 8-bit shift register, clear counters, go to START.
- START: tx=0. At baud terminal count, go to DATA with bit_idx=0.
- DATA: tx=shift[0], LSB first. At terminal count, shift right. bit_idx 7 goes to STOP; otherwise increment bit_idx.
- STOP: tx=1. At terminal count:
  - FIFO non-empty: pop and go directly to START. No idle cycle, so back-to-back frames run exactly 10*CLKS_PER_BIT apart.
  - Otherwise go to IDLE.
- Latency: a byte accepted at edge N into an empty FIFO with FSM idle is popped at edge N+1. tx goes low after edge N+1.
  - Frame length is 10*CLKS_PER_BIT cycles.
- Simultaneous push and pop when not full: both occur, count unchanged.
- Push on empty while idle: FIFO count goes to 1 for one cycle, then pops.
- busy = (state != IDLE) || !empty, combinational.
- FIFO pointers are log2(FIFO_DEPTH) bits wide with natural wrap. Count is log2(FIFO_DEPTH)+1 bits.
  - full = (count==FIFO_DEPTH). empty = (count==0).

Decomposition:
- Package uart_pkg:
  - tx_state_t enum {IDLE, START, DATA, STOP}.
  - Function clks_per_bit(CLK_HZ, BAUD).
  - Constants for data bits (8) and frame bits (10).
- Sub-module sample_fifo:
  - Synchronous single-clock FIFO with params WIDTH=8 and DEPTH.
  - Ports clk, rst, push, din, pop, dout (head, first-word-fall-through), full, empty.
- Top level holds the FSM, the baud counter, the bit index, the shift register and the overflow flag.

Test Plan (CLK_HZ=1_000_000, BAUD=250_000, so CLKS_PER_BIT=4 and a frame is 40 cycles; FIFO_DEPTH=4):
- Reset then idle 100 cycles -> tx=1, busy=0, in_ready=1, overflow=0 throughout.
- Single write 0xA5 at edge N -> tx low from edge N+1 for 4 cycles. Then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then stop high. busy drops at edge N+41.
- Write 0x00, 0xFF, 0x80 on consecutive cycles -> three contiguous 40-cycle frames, no gap between stop and next start, decoded bytes in order.
- Write 6 bytes on consecutive cycles starting while idle -> first pops after 1 cycle, so 4 remain buffered. in_ready low from the 5th accepted write. 6th byte dropped, overflow=1 sticky. Exactly 5 frames transmitted.
- Assert rst during DATA bit 3 of 0x3C, with 2 bytes queued -> tx=1 immediately, busy=0, FIFO empty. No further frames after release.
- Hold in_valid for 200 cycles with incrementing data 0..N (triangle-like ramp) -> every transmitted byte equals its accepted value in order. Accept rate matches 1 byte per 40 cycles once full.
